pattern_generator: RTL and testbench

- Transmit-side counterpart of the team's serial vehicle-pattern detectors.
- Serialises a programmable symbol pattern (BIKE=0, CAR=1) onto a 1-bit valid/ready stream.
- Supports a programmable repeat count and an idle gap between instances.
- Drives detector benches and the traffic-stimulus path; default use is BCCBC (len 5, pattern 5'b10110, bit 0 sent first).

---
 rtl/pattern_gen_pkg.sv | 23 ++
 rtl/pattern_gen_shift.sv | 44 ++++
 rtl/pattern_generator.sv | 126 ++++++++++++
 tb/tb_pattern_generator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pattern_gen_pkg
// Brief    : Shared state encoding and symbol constants for pattern_generator.
// Revision : 1.0 - initial release
// ============================================================================
package pattern_gen_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        SEND = 4'b0010,
        GAP  = 4'b0100,
        DONE = 4'b1000
    } state_t;

    localparam logic BIKE = 1'b0;
    localparam logic CAR  = 1'b1;

    localparam logic [4:0] BCCBC_PATTERN = 5'b10110;
    localparam int         BCCBC_LEN     = 5;

endpackage
`default_nettype wire

// File: rtl/pattern_gen_shift.sv
`default_nettype none
// ============================================================================
// Module   : pattern_gen_shift
// Brief    : Captured pattern register with symbol index and last-bit flag.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_gen_shift #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load,
    input  logic               advance,
    input  logic [MAX_LEN-1:0] pattern_in,
    input  logic [LEN_W-1:0]   len_in,
    output logic               d_out,
    output logic               last_bit
);

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_bit_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_bit_idx <= '0;
        end else if (load) begin
            r_pattern <= pattern_in;
            r_len     <= len_in;
            r_bit_idx <= '0;
        end else if (advance) begin
            r_bit_idx <= last_bit ? '0 : r_bit_idx + LEN_W'(1);
        end
    end

    // Mask select avoids an index wider than the pattern vector needs.
    assign d_out    = |(r_pattern & (MAX_LEN'(1) << r_bit_idx));
    assign last_bit = (r_bit_idx == r_len - LEN_W'(1));

endmodule
`default_nettype wire

// File: rtl/pattern_generator.sv
`default_nettype none
// ============================================================================
// Module   : pattern_generator
// Brief    : Serialises a programmable symbol pattern onto a valid/ready stream
//            with repeat count and inter-instance gap. Optional abort input is
//            enabled by defining PATGEN_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_generator
    import pattern_gen_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [CNT_W-1:0]   repeat_i,
    input  logic [CNT_W-1:0]   gap_i,
    input  logic               ready_i,
`ifdef PATGEN_ABORT_EN
    input  logic               abort_i,
`endif
    output logic               valid_o,
    output logic               d_out,
    output logic               busy_o,
    output logic               done_o
);

    state_t           r_state;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [CNT_W-1:0] r_gap_q;
    logic [CNT_W-1:0] r_gap_cnt;

    logic w_legal;
    logic w_load;
    logic w_xfer;
    logic w_abort;
    logic w_advance;
    logic w_symbol;
    logic w_last;

    assign w_legal = (len_i != '0) && (len_i <= LEN_W'(MAX_LEN)) && (repeat_i != '0);
    assign w_load  = (r_state == IDLE) && start_i && w_legal;
    assign w_xfer  = (r_state == SEND) && ready_i;

`ifdef PATGEN_ABORT_EN
    assign w_abort = abort_i && (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // An abort in the same cycle as a transfer drops that symbol.
    assign w_advance = w_xfer && !w_abort;

    pattern_gen_shift #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shift (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (w_load),
        .advance    (w_advance),
        .pattern_in (pattern_i),
        .len_in     (len_i),
        .d_out      (w_symbol),
        .last_bit   (w_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_rep_cnt <= '0;
            r_gap_q   <= '0;
            r_gap_cnt <= '0;
        end else if (w_abort) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state   <= SEND;
                        r_rep_cnt <= repeat_i;
                        r_gap_q   <= gap_i;
                        r_gap_cnt <= '0;
                    end
                end
                SEND: begin
                    if (w_xfer && w_last) begin
                        r_rep_cnt <= (r_rep_cnt != '0) ? r_rep_cnt - CNT_W'(1) : '0;
                        if (r_rep_cnt <= CNT_W'(1)) begin
                            r_state <= DONE;
                        end else if (r_gap_q == '0) begin
                            r_state <= SEND;
                        end else begin
                            r_state   <= GAP;
                            r_gap_cnt <= r_gap_q;
                        end
                    end
                end
                GAP: begin
                    r_gap_cnt <= (r_gap_cnt != '0) ? r_gap_cnt - CNT_W'(1) : '0;
                    if (r_gap_cnt <= CNT_W'(1)) begin
                        r_state <= SEND;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign valid_o = (r_state == SEND);
    assign d_out   = (r_state == SEND) && w_symbol;
    assign busy_o  = (r_state != IDLE);
    assign done_o  = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_generator
// Brief    : Self-checking bench for pattern_generator (table + random runs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_generator;
    import pattern_gen_pkg::*;

    localparam int MAXC = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [7:0] rep;
    logic [7:0] gap;
    logic       ready;
    logic       valid;
    logic       dout;
    logic       busy;
    logic       done;
`ifdef PATGEN_ABORT_EN
    logic       abort = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    bit ready_arr [MAXC];
    bit exp_v     [MAXC];
    bit exp_d     [MAXC];

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [7:0]  rep;
        logic [7:0]  gap;
        logic [31:0] mask;
        int          want_done;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    pattern_generator #(
        .MAX_LEN (8),
        .LEN_W   (4),
        .CNT_W   (8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .pattern_i (pattern),
        .len_i     (len),
        .repeat_i  (rep),
        .gap_i     (gap),
        .ready_i   (ready),
`ifdef PATGEN_ABORT_EN
        .abort_i   (abort),
`endif
        .valid_o   (valid),
        .d_out     (dout),
        .busy_o    (busy),
        .done_o    (done)
    );

    task automatic chk(input string name, input int cyc, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_idle(input string name, input int cyc);
        chk({name, ".valid"}, cyc, valid, 1'b0);
        chk({name, ".busy"},  cyc, busy,  1'b0);
        chk({name, ".done"},  cyc, done,  1'b0);
    endtask

    // Expected per-cycle stream: each symbol occupies cycles until ready is seen,
    // instances separated by gap idle cycles, then one DONE cycle.
    task automatic run_check(input string name, input logic [7:0] p, input logic [3:0] l,
                             input logic [7:0] r, input logic [7:0] g,
                             input logic [31:0] mask, input int stall_pct, input int want_done);
        int c;
        int end_c;
        int obs_done;
        for (int i = 0; i < MAXC; i++) begin
            exp_v[i] = 1'b0;
            exp_d[i] = 1'b0;
            if (i < 32 && mask[i])  ready_arr[i] = 1'b0;
            else if (i >= 200)      ready_arr[i] = 1'b1;
            else                    ready_arr[i] = ($urandom_range(99) >= stall_pct);
        end
        c = 1;
        for (int k = 0; k < int'(r); k++) begin
            for (int b = 0; b < int'(l); b++) begin
                do begin
                    exp_v[c] = 1'b1;
                    exp_d[c] = p[b];
                    c++;
                end while (!ready_arr[c-1]);
            end
            if (k < int'(r) - 1) c += int'(g);
        end
        end_c    = c;
        obs_done = -1;
        for (int cy = 0; cy <= end_c + 1; cy++) begin
            @(posedge clk); #1;
            if (cy == 0) begin
                start = 1'b1; pattern = p; len = l; rep = r; gap = g;
            end else begin
                start   = (cy <= end_c) ? 1'($urandom_range(1)) : 1'b0;
                pattern = 8'($urandom);
                len     = 4'($urandom);
                rep     = 8'($urandom);
                gap     = 8'($urandom_range(3));
            end
            ready = ready_arr[cy];
            @(negedge clk);
            chk({name, ".valid"}, cy, valid, exp_v[cy]);
            if (exp_v[cy]) chk({name, ".d_out"}, cy, dout, exp_d[cy]);
            chk({name, ".busy"}, cy, busy, (cy >= 1 && cy <= end_c));
            chk({name, ".done"}, cy, done, (cy == end_c));
            if (done && obs_done < 0) obs_done = cy;
        end
        if (want_done >= 0) begin
            vectors++;
            if (obs_done != want_done) begin
                miscompares++;
                $display("FAIL %s.done_cycle: got %0d expected %0d", name, obs_done, want_done);
            end
        end
    endtask

    task automatic try_illegal(input string name, input logic [3:0] l, input logic [7:0] r);
        @(posedge clk); #1;
        start = 1'b1; pattern = 8'h16; len = l; rep = r; gap = 8'd0; ready = 1'b1;
        for (int cy = 1; cy <= 3; cy++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk_idle(name, cy);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h16, 4'd5, 8'd1, 8'd0, 32'h0,  6};
        tbl[1] = '{8'h16, 4'd5, 8'd1, 8'd0, 32'h1C, 9};
        tbl[2] = '{8'h16, 4'd5, 8'd3, 8'd0, 32'h0,  16};
        tbl[3] = '{8'h16, 4'd5, 8'd2, 8'd2, 32'h0,  13};
        tbl[4] = '{8'hA5, 4'd8, 8'd1, 8'd0, 32'h0,  9};
        tbl[5] = '{8'h01, 4'd1, 8'd4, 8'd1, 32'h0,  8};

        rst = 1'b1; start = 1'b0; pattern = '0; len = '0; rep = '0; gap = '0; ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset", 0);
        chk("reset.d_out", 0, dout, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_check($sformatf("vec%0d", i), tbl[i].pat, tbl[i].len, tbl[i].rep,
                      tbl[i].gap, tbl[i].mask, 0, tbl[i].want_done);

        try_illegal("len0",   4'd0,  8'd1);
        try_illegal("len9",   4'd9,  8'd1);
        try_illegal("rep0",   4'd5,  8'd0);
        try_illegal("len15",  4'd15, 8'd3);

        // Reset after the third transfer of a BCCBC run.
        @(posedge clk); #1;
        start = 1'b1; pattern = {3'b000, BCCBC_PATTERN}; len = 4'(BCCBC_LEN);
        rep = 8'd1; gap = 8'd0; ready = 1'b1;
        for (int cy = 1; cy <= 4; cy++) begin
            @(posedge clk); #1;
            start = 1'b0;
            rst   = (cy == 4);
            @(negedge clk);
            chk("rstmid.valid", cy, valid, 1'b1);
            chk("rstmid.d_out", cy, dout, BCCBC_PATTERN[cy-1]);
        end
        for (int cy = 5; cy <= 7; cy++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk_idle("rstmid", cy);
        end
        run_check("replay", 8'h16, 4'd5, 8'd1, 8'd0, 32'h0, 0, 6);

`ifdef PATGEN_ABORT_EN
        @(posedge clk); #1;
        start = 1'b1; pattern = 8'h16; len = 4'd5; rep = 8'd1; gap = 8'd0; ready = 1'b1;
        for (int cy = 1; cy <= 3; cy++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = (cy == 3);
            @(negedge clk);
            chk("abort.valid", cy, valid, 1'b1);
        end
        for (int cy = 4; cy <= 7; cy++) begin
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            chk_idle("abort", cy);
        end
        @(posedge clk); #1;
        start = 1'b1;
        for (int cy = 1; cy <= 2; cy++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = (cy == 2);
            rst   = (cy == 2);
            @(negedge clk);
        end
        @(posedge clk); #1;
        abort = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk_idle("abortrst", 3);
        chk("abortrst.d_out", 3, dout, 1'b0);
        run_check("postabort", 8'h16, 4'd5, 8'd1, 8'd0, 32'h0, 0, 6);
`endif

        for (int i = 0; i < 30; i++)
            run_check($sformatf("rand%0d", i), 8'($urandom), 4'($urandom_range(8, 1)),
                      8'($urandom_range(4, 1)), 8'($urandom_range(3)), 32'h0, 30, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
